// File: rtl/calc_input_sequencer.sv
// Calculator key sequencer: builds BCD operands and an operator from keypad events, runs the ALU
// with a start/done handshake and picks the display source. Outputs are registered.
module calc_input_sequencer #(
  parameter  int DIGITS  = 4,
  parameter  int TIMEOUT = 1024,
  localparam int W       = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  output logic         alu_start,
  output logic [1:0]   alu_opcode,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic         alu_done,
  input  logic         alu_err,
  input  logic [W-1:0] alu_result,
  output logic [W-1:0] disp_data,
  output logic [2:0]   state_o,
  output logic         busy,
  output logic         err
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_RES  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t        state, nxt_state;
  logic [W-1:0]  a, nxt_a, b, nxt_b;
  logic [1:0]    opcode, nxt_opcode, pending, nxt_pending;
  logic [CW-1:0] count_a, nxt_count_a, count_b, nxt_count_b;
  logic          chain, nxt_chain;
  logic [TW-1:0] timer, nxt_timer;
  logic [W-1:0]  nxt_disp;

  logic          is_digit, is_op, is_eq, is_clr;
  logic [1:0]    key_op;
  logic [W-1:0]  key_ext;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_op    = key_valid && (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_eq    = key_valid && (key_code == 4'd14);
  assign is_clr   = key_valid && (key_code == 4'd15);
  // Keys 10..13 map to opcodes 0..3 by flipping bit 1 of the low pair.
  assign key_op   = key_code[1:0] ^ 2'b10;
  assign key_ext  = {{(W-4){1'b0}}, key_code};

  always_comb begin
    nxt_state   = state;
    nxt_a       = a;
    nxt_b       = b;
    nxt_opcode  = opcode;
    nxt_pending = pending;
    nxt_count_a = count_a;
    nxt_count_b = count_b;
    nxt_chain   = chain;
    nxt_timer   = timer;
    case (state)
      S_A: begin
        if (is_digit && count_a < CW'(DIGITS)) begin
          nxt_a       = {a[W-5:0], key_code};
          nxt_count_a = count_a + 1'b1;
        end else if (is_op) begin
          nxt_opcode = key_op;
          nxt_state  = S_OP;
        end
      end
      S_OP: begin
        if (is_op) begin
          nxt_opcode = key_op;
        end else if (is_digit) begin
          nxt_b       = key_ext;
          nxt_count_b = CW'(1);
          nxt_state   = S_B;
        end
      end
      S_B: begin
        if (is_digit && count_b < CW'(DIGITS)) begin
          nxt_b       = {b[W-5:0], key_code};
          nxt_count_b = count_b + 1'b1;
        end else if (is_eq || is_op) begin
          nxt_chain   = is_op;
          nxt_pending = is_op ? key_op : pending;
          nxt_timer   = '0;
          nxt_state   = S_EXEC;
        end
      end
      S_EXEC: begin
        nxt_timer = timer + 1'b1;
        if (alu_done) begin
          if (alu_err) begin
            nxt_state = S_ERR;
          end else begin
            nxt_a       = alu_result;
            nxt_count_a = CW'(DIGITS);
            nxt_chain   = 1'b0;
            if (chain) begin
              nxt_opcode = pending;
              nxt_state  = S_OP;
            end else begin
              nxt_state  = S_RES;
            end
          end
        end else if (timer == TW'(TIMEOUT - 1)) begin
          nxt_state = S_ERR;
        end
      end
      S_RES: begin
        if (is_digit) begin
          nxt_a       = key_ext;
          nxt_count_a = CW'(1);
          nxt_state   = S_A;
        end else if (is_op) begin
          nxt_opcode = key_op;
          nxt_state  = S_OP;
        end
      end
      S_ERR:   ;
      default: nxt_state = S_A;
    endcase
    // Clear overrides everything, including a coincident alu_done.
    if (is_clr) begin
      nxt_state   = S_A;
      nxt_a       = '0;
      nxt_b       = '0;
      nxt_opcode  = 2'd0;
      nxt_pending = 2'd0;
      nxt_count_a = '0;
      nxt_count_b = '0;
      nxt_chain   = 1'b0;
      nxt_timer   = '0;
    end
  end

  always_comb begin
    nxt_disp = nxt_a;
    case (nxt_state)
      S_B, S_EXEC: nxt_disp = nxt_b;
      S_ERR:       nxt_disp = {DIGITS{4'hE}};
      default:     nxt_disp = nxt_a;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_A;
      a         <= '0;
      b         <= '0;
      opcode    <= 2'd0;
      pending   <= 2'd0;
      count_a   <= '0;
      count_b   <= '0;
      chain     <= 1'b0;
      timer     <= '0;
      alu_start <= 1'b0;
      disp_data <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= nxt_state;
      a         <= nxt_a;
      b         <= nxt_b;
      opcode    <= nxt_opcode;
      pending   <= nxt_pending;
      count_a   <= nxt_count_a;
      count_b   <= nxt_count_b;
      chain     <= nxt_chain;
      timer     <= nxt_timer;
      alu_start <= (nxt_state == S_EXEC) && (state != S_EXEC);
      disp_data <= nxt_disp;
      busy      <= (nxt_state == S_EXEC);
      err       <= (nxt_state == S_ERR);
    end
  end

  assign alu_a      = a;
  assign alu_b      = b;
  assign alu_opcode = opcode;
  assign state_o    = state;

endmodule
